// File: rtl/seq_stream_parser.sv
`default_nettype none
// ============================================================================
// Module   : seq_stream_parser
// Purpose  : Parses 32-bit little-endian framed messages, tracks per-stream
//            sequence numbers and queues parsed messages in an output FIFO.
//            Optional macro SEQ_GAP_COUNT_EN adds the dataOut_gap output.
// Revision : 1.0 - initial release
// ============================================================================
module seq_stream_parser #(
  parameter int NUM_STREAMS   = 32,
  parameter int MAX_PAYLOAD   = 37,
  parameter int OUT_DEPTH     = 2,
  parameter int LEN_W         = 16,
  localparam int DATA_W       = MAX_PAYLOAD * 8
) (
  input  logic              clk,
  input  logic              reset_b,
  input  logic [31:0]       dataIn,
  input  logic              dataIn_val,
  output logic              dataIn_ready,
  input  logic              dataIn_last,
  output logic [DATA_W-1:0] dataOut,
  output logic [LEN_W-1:0]  dataOut_len,
  output logic [15:0]       dataOut_stream,
  output logic              dataOut_val,
  input  logic              dataOut_ready,
  output logic              packetLost,
  output logic              packetErr
`ifdef SEQ_GAP_COUNT_EN
  ,
  output logic [31:0]       dataOut_gap
`endif
);

  localparam int c_SID_W = $clog2(NUM_STREAMS);
  localparam int c_CNT_W = $clog2(MAX_PAYLOAD + 5);
  localparam int c_PTR_W = (OUT_DEPTH > 1) ? $clog2(OUT_DEPTH) : 1;
  localparam int c_OCC_W = $clog2(OUT_DEPTH + 1);

  localparam logic [c_CNT_W-1:0] c_MAX      = c_CNT_W'(MAX_PAYLOAD);
  localparam logic [16:0]        c_NUM      = 17'(NUM_STREAMS);
  localparam logic [c_PTR_W-1:0] c_LAST_PTR = c_PTR_W'(OUT_DEPTH - 1);
  localparam logic [c_OCC_W-1:0] c_FULL     = c_OCC_W'(OUT_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_HDR2 = 2'd1,
    S_DATA = 2'd2
  } state_t;

  state_t r_state;
  state_t w_stateNext;

  // Message assembly registers
  logic [DATA_W-1:0]  r_data;
  logic [c_CNT_W-1:0] r_count;
  logic [LEN_W-1:0]   r_rem;
  logic               r_err;
  logic               r_badHdr;
  logic [15:0]        r_stream;
  logic [31:0]        r_seq;

  logic [DATA_W-1:0]  w_dataNext;
  logic [c_CNT_W-1:0] w_countNext;
  logic [LEN_W-1:0]   w_remNext;
  logic               w_errNext;
  logic               w_badHdrNext;
  logic [15:0]        w_streamNext;
  logic [31:0]        w_seqNext;
  logic               w_push;
  logic               w_hdrErr;

  logic [31:0] r_seqs [NUM_STREAMS];

  // Output FIFO
  logic [DATA_W-1:0]  r_fData   [OUT_DEPTH];
  logic [c_CNT_W-1:0] r_fLen    [OUT_DEPTH];
  logic [15:0]        r_fStream [OUT_DEPTH];
  logic               r_fLost   [OUT_DEPTH];
  logic               r_fErr    [OUT_DEPTH];
`ifdef SEQ_GAP_COUNT_EN
  logic [31:0]        r_fGap    [OUT_DEPTH];
  logic [31:0]        w_entryGap;
`endif
  logic [c_PTR_W-1:0] r_wrPtr;
  logic [c_PTR_W-1:0] r_rdPtr;
  logic [c_OCC_W-1:0] r_occ;

  logic               w_full;
  logic               w_accept;
  logic               w_pop;

  logic [7:0]         w_byte [4];
  logic [15:0]        w_wordLen;
  logic [15:0]        w_wordStream;
  logic [31:0]        w_wordSeq;
  logic [2:0]         w_valid;
  logic [c_CNT_W-1:0] w_countSum;
  logic               w_overflow;

  logic               w_pushBad;
  logic [c_SID_W-1:0] w_sid;
  logic               w_streamOk;
  logic               w_seqOk;
  logic [31:0]        w_expected;
  logic               w_entryLost;
  logic               w_entryErr;

  assign w_byte[0]    = dataIn[31:24];
  assign w_byte[1]    = dataIn[23:16];
  assign w_byte[2]    = dataIn[15:8];
  assign w_byte[3]    = dataIn[7:0];
  assign w_wordLen    = {w_byte[1], w_byte[0]};
  assign w_wordStream = {w_byte[3], w_byte[2]};
  assign w_wordSeq    = {w_byte[3], w_byte[2], w_byte[1], w_byte[0]};

  assign w_full       = (r_occ == c_FULL);
  assign dataIn_ready = !w_full;
  assign w_accept     = dataIn_val && !w_full;
  assign dataOut_val  = (r_occ != '0);
  assign w_pop        = dataOut_val && dataOut_ready;

  // Bytes of the current word that still belong to the payload
  assign w_valid    = (r_rem >= LEN_W'(4)) ? 3'd4 : r_rem[2:0];
  assign w_countSum = r_count + c_CNT_W'(w_valid);
  assign w_overflow = (w_countSum > c_MAX);

  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_stateNext;
    end
  end

  always_comb begin
    w_stateNext  = r_state;
    w_push       = 1'b0;
    w_hdrErr     = 1'b0;
    w_dataNext   = r_data;
    w_countNext  = r_count;
    w_remNext    = r_rem;
    w_errNext    = r_err;
    w_badHdrNext = r_badHdr;
    w_streamNext = r_stream;
    w_seqNext    = r_seq;
    if (w_accept) begin
      unique case (r_state)
        S_IDLE: begin
          w_dataNext   = '0;
          w_countNext  = '0;
          w_errNext    = 1'b0;
          w_streamNext = w_wordStream;
          w_badHdrNext = (w_wordLen < 16'd8);
          w_remNext    = w_badHdrNext ? '0 : LEN_W'(w_wordLen - 16'd8);
          if (dataIn_last) begin
            w_push   = 1'b1;
            w_hdrErr = 1'b1;
          end else begin
            w_stateNext = S_HDR2;
          end
        end
        S_HDR2: begin
          w_seqNext = w_wordSeq;
          if (dataIn_last) begin
            w_push      = 1'b1;
            w_errNext   = r_err | (r_rem != '0);
            w_stateNext = S_IDLE;
          end else begin
            w_stateNext = S_DATA;
          end
        end
        S_DATA: begin
          // r_count is word-aligned whenever bytes are still being stored
          for (int k = 0; k < MAX_PAYLOAD; k++) begin
            if ((c_CNT_W'(k) >= r_count) && (c_CNT_W'(k) < w_countSum)) begin
              w_dataNext[DATA_W-1-8*k -: 8] = w_byte[k % 4];
            end
          end
          w_countNext = w_overflow ? c_MAX : w_countSum;
          w_remNext   = r_rem - LEN_W'(w_valid);
          w_errNext   = r_err | w_overflow | (r_rem == '0) |
                        (dataIn_last ? (r_rem > LEN_W'(4)) : (r_rem <= LEN_W'(4)));
          if (dataIn_last) begin
            w_push      = 1'b1;
            w_stateNext = S_IDLE;
          end
        end
        default: begin
          w_stateNext = S_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      r_data   <= '0;
      r_count  <= '0;
      r_rem    <= '0;
      r_err    <= 1'b0;
      r_badHdr <= 1'b0;
      r_stream <= '0;
      r_seq    <= '0;
    end else if (w_accept) begin
      r_data   <= w_dataNext;
      r_count  <= w_countNext;
      r_rem    <= w_remNext;
      r_err    <= w_errNext;
      r_badHdr <= w_badHdrNext;
      r_stream <= w_streamNext;
      r_seq    <= w_seqNext;
    end
  end

  // Header-level errors never touch the sequence table
  assign w_pushBad   = w_hdrErr | w_badHdrNext;
  assign w_sid       = w_streamNext[c_SID_W-1:0];
  assign w_streamOk  = ({1'b0, w_streamNext} < c_NUM);
  assign w_seqOk     = !w_pushBad && w_streamOk;
  assign w_expected  = r_seqs[w_sid] + 32'd1;
  assign w_entryLost = w_seqOk && (w_seqNext != w_expected);
  assign w_entryErr  = w_errNext | w_pushBad | !w_streamOk;
`ifdef SEQ_GAP_COUNT_EN
  assign w_entryGap  = w_entryLost ? (w_seqNext - w_expected) : '0;
`endif

  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      for (int i = 0; i < NUM_STREAMS; i++) begin
        r_seqs[i] <= '0;
      end
    end else if (w_push && w_seqOk) begin
      r_seqs[w_sid] <= w_seqNext;
    end
  end

  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_occ   <= '0;
    end else begin
      if (w_push) begin
        r_wrPtr <= (r_wrPtr == c_LAST_PTR) ? '0 : r_wrPtr + c_PTR_W'(1);
      end
      if (w_pop) begin
        r_rdPtr <= (r_rdPtr == c_LAST_PTR) ? '0 : r_rdPtr + c_PTR_W'(1);
      end
      if (w_push && !w_pop) begin
        r_occ <= r_occ + c_OCC_W'(1);
      end else if (w_pop && !w_push) begin
        r_occ <= r_occ - c_OCC_W'(1);
      end
    end
  end

  // Entry storage needs no reset: every output is gated by dataOut_val
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_fData[r_wrPtr]   <= w_dataNext;
      r_fLen[r_wrPtr]    <= w_countNext;
      r_fStream[r_wrPtr] <= w_streamNext;
      r_fLost[r_wrPtr]   <= w_entryLost;
      r_fErr[r_wrPtr]    <= w_entryErr;
`ifdef SEQ_GAP_COUNT_EN
      r_fGap[r_wrPtr]    <= w_entryGap;
`endif
    end
  end

  assign dataOut        = dataOut_val ? r_fData[r_rdPtr] : '0;
  assign dataOut_len    = dataOut_val ? LEN_W'(r_fLen[r_rdPtr]) : '0;
  assign dataOut_stream = dataOut_val ? r_fStream[r_rdPtr] : '0;
  assign packetLost     = dataOut_val && r_fLost[r_rdPtr];
  assign packetErr      = dataOut_val && r_fErr[r_rdPtr];
`ifdef SEQ_GAP_COUNT_EN
  assign dataOut_gap    = dataOut_val ? r_fGap[r_rdPtr] : '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_seq_stream_parser.sv
`default_nettype none
// Directed bench for seq_stream_parser: hand-built messages, immediate-assertion checks.
module tb_seq_stream_parser;
  localparam int DW = 37 * 8;

  logic          clk = 1'b0;
  logic          reset_b;
  logic [31:0]   dataIn;
  logic          dataIn_val;
  logic          dataIn_ready;
  logic          dataIn_last;
  logic [DW-1:0] dataOut;
  logic [15:0]   dataOut_len;
  logic [15:0]   dataOut_stream;
  logic          dataOut_val;
  logic          dataOut_ready;
  logic          packetLost;
  logic          packetErr;
`ifdef SEQ_GAP_COUNT_EN
  logic [31:0]   dataOut_gap;
`endif

  int nVec = 0;
  int nErr = 0;
  logic bgDone = 1'b0;

  seq_stream_parser dut (
    .clk            (clk),
    .reset_b        (reset_b),
    .dataIn         (dataIn),
    .dataIn_val     (dataIn_val),
    .dataIn_ready   (dataIn_ready),
    .dataIn_last    (dataIn_last),
    .dataOut        (dataOut),
    .dataOut_len    (dataOut_len),
    .dataOut_stream (dataOut_stream),
    .dataOut_val    (dataOut_val),
    .dataOut_ready  (dataOut_ready),
    .packetLost     (packetLost),
    .packetErr      (packetErr)
`ifdef SEQ_GAP_COUNT_EN
    ,
    .dataOut_gap    (dataOut_gap)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chkB(input string tag, input logic obs, input logic exp);
    nVec++;
    assert (obs === exp) else begin
      nErr++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    nVec++;
    assert (obs === exp) else begin
      nErr++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nVec++;
    assert (obs === exp) else begin
      nErr++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chkD(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    nVec++;
    assert (obs === exp) else begin
      nErr++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] hdrWord(input logic [15:0] len, input logic [15:0] sid);
    return {len[7:0], len[15:8], sid[7:0], sid[15:8]};
  endfunction

  function automatic logic [31:0] seqWord(input logic [31:0] s);
    return {s[7:0], s[15:8], s[23:16], s[31:24]};
  endfunction

  // Payload byte k carries the value k+1
  function automatic logic [31:0] payWord(input int w);
    return {8'(4*w+1), 8'(4*w+2), 8'(4*w+3), 8'(4*w+4)};
  endfunction

  function automatic logic [DW-1:0] expData(input int n);
    logic [DW-1:0] d;
    d = '0;
    for (int k = 0; k < n; k++) d[DW-1-8*k -: 8] = 8'(k + 1);
    return d;
  endfunction

  task automatic sendWord(input logic [31:0] w, input logic l);
    int waitCyc;
    waitCyc = 0;
    dataIn      = w;
    dataIn_last = l;
    dataIn_val  = 1'b1;
    @(negedge clk);
    while (!dataIn_ready && waitCyc < 200) begin
      @(negedge clk);
      waitCyc++;
    end
    if (!dataIn_ready) chkB("sendWord.ready_timeout", dataIn_ready, 1'b1);
    @(posedge clk);
    #1;
    dataIn_val  = 1'b0;
    dataIn_last = 1'b0;
  endtask

  task automatic sendMsg(input logic [15:0] len, input logic [15:0] sid,
                         input logic [31:0] s, input int nWords);
    sendWord(hdrWord(len, sid), 1'b0);
    sendWord(seqWord(s), nWords == 0);
    for (int w = 0; w < nWords; w++) sendWord(payWord(w), w == nWords - 1);
  endtask

  task automatic expectHead(input string tag, input logic [DW-1:0] d, input logic [15:0] len,
                            input logic [15:0] sid, input logic lost, input logic err,
                            input logic [31:0] gap);
    int waitCyc;
    waitCyc = 0;
    while (!dataOut_val && waitCyc < 200) begin
      @(negedge clk);
      waitCyc++;
    end
    chkB({tag, ".val"}, dataOut_val, 1'b1);
    chkD({tag, ".data"}, dataOut, d);
    chk16({tag, ".len"}, dataOut_len, len);
    chk16({tag, ".stream"}, dataOut_stream, sid);
    chkB({tag, ".lost"}, packetLost, lost);
    chkB({tag, ".err"}, packetErr, err);
`ifdef SEQ_GAP_COUNT_EN
    chk32({tag, ".gap"}, dataOut_gap, gap);
`else
    if (gap != 32'd0 && waitCyc < 0) chk32({tag, ".gap"}, gap, 32'd0);
`endif
    dataOut_ready = 1'b1;
    @(posedge clk);
    #1;
    dataOut_ready = 1'b0;
  endtask

  initial begin
    reset_b       = 1'b0;
    dataIn        = '0;
    dataIn_val    = 1'b0;
    dataIn_last   = 1'b0;
    dataOut_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chkB("rst.val", dataOut_val, 1'b0);
    chkB("rst.ready", dataIn_ready, 1'b1);
    chkD("rst.data", dataOut, '0);
    chk16("rst.len", dataOut_len, 16'd0);
    chkB("rst.lost", packetLost, 1'b0);
    chkB("rst.err", packetErr, 1'b0);
    @(negedge clk);
    reset_b = 1'b1;
    @(posedge clk);
    #1;

    // 13-byte payload, last word keeps 1 byte
    sendMsg(16'h0015, 16'd3, 32'd1, 4);
    chkB("t1.latency", dataOut_val, 1'b1);
    expectHead("t1", expData(13), 16'd13, 16'd3, 1'b0, 1'b0, 32'd0);
    chkB("t1.empty", dataOut_val, 1'b0);

    // Sequence gap on stream 5
    sendMsg(16'd12, 16'd5, 32'd1, 1);
    expectHead("t2a", expData(4), 16'd4, 16'd5, 1'b0, 1'b0, 32'd0);
    sendMsg(16'd12, 16'd5, 32'd4, 1);
    expectHead("t2b", expData(4), 16'd4, 16'd5, 1'b1, 1'b0, 32'd2);
    sendMsg(16'd12, 16'd5, 32'd5, 1);
    expectHead("t2c", expData(4), 16'd4, 16'd5, 1'b0, 1'b0, 32'd0);

    // Sequence wrap on stream 7
    sendMsg(16'd12, 16'd7, 32'hFFFF_FFFF, 1);
    expectHead("t3a", expData(4), 16'd4, 16'd7, 1'b1, 1'b0, 32'hFFFF_FFFE);
    sendMsg(16'd12, 16'd7, 32'd0, 1);
    expectHead("t3b", expData(4), 16'd4, 16'd7, 1'b0, 1'b0, 32'd0);

    // Out-of-range stream leaves the table (incl. aliased entry 8) alone
    sendMsg(16'd12, 16'd40, 32'd5, 1);
    expectHead("t4a", expData(4), 16'd4, 16'd40, 1'b0, 1'b1, 32'd0);
    sendMsg(16'd12, 16'd8, 32'd1, 1);
    expectHead("t4b", expData(4), 16'd4, 16'd8, 1'b0, 1'b0, 32'd0);

    // Oversized payload truncated to 37 bytes
    sendMsg(16'd60, 16'd9, 32'd1, 13);
    expectHead("t5a", expData(37), 16'd37, 16'd9, 1'b0, 1'b1, 32'd0);
    sendMsg(16'd12, 16'd9, 32'd2, 1);
    expectHead("t5b", expData(4), 16'd4, 16'd9, 1'b0, 1'b0, 32'd0);

    // Last on word0
    sendWord(hdrWord(16'd12, 16'd13), 1'b1);
    expectHead("t6a", '0, 16'd0, 16'd13, 1'b0, 1'b1, 32'd0);
    sendMsg(16'd12, 16'd13, 32'd1, 1);
    expectHead("t6b", expData(4), 16'd4, 16'd13, 1'b0, 1'b0, 32'd0);

    // Last on word1, with and without a declared payload
    sendMsg(16'd12, 16'd14, 32'd1, 0);
    expectHead("t7a", '0, 16'd0, 16'd14, 1'b0, 1'b1, 32'd0);
    sendMsg(16'd8, 16'd14, 32'd2, 0);
    expectHead("t7b", '0, 16'd0, 16'd14, 1'b0, 1'b0, 32'd0);

    // Early last, then surplus words
    sendMsg(16'd20, 16'd15, 32'd1, 1);
    expectHead("t8", expData(4), 16'd4, 16'd15, 1'b0, 1'b1, 32'd0);
    sendMsg(16'd12, 16'd16, 32'd1, 3);
    expectHead("t9", expData(4), 16'd4, 16'd16, 1'b0, 1'b1, 32'd0);

    // FIFO full back-pressure
    sendMsg(16'd12, 16'd10, 32'd1, 1);
    chkB("t10.ready1", dataIn_ready, 1'b1);
    sendMsg(16'd16, 16'd10, 32'd2, 2);
    chkB("t10.full", dataIn_ready, 1'b0);
    fork
      begin
        sendMsg(16'd9, 16'd10, 32'd3, 1);
        bgDone = 1'b1;
      end
    join_none
    repeat (5) @(posedge clk);
    #1;
    chkB("t10.stall", bgDone, 1'b0);
    expectHead("t10a", expData(4), 16'd4, 16'd10, 1'b0, 1'b0, 32'd0);
    expectHead("t10b", expData(8), 16'd8, 16'd10, 1'b0, 1'b0, 32'd0);
    for (int i = 0; i < 100 && !bgDone; i++) @(posedge clk);
    #1;
    chkB("t10.done", bgDone, 1'b1);
    expectHead("t10c", expData(1), 16'd1, 16'd10, 1'b0, 1'b0, 32'd0);

    // Reset in the middle of a message with an entry pending
    sendMsg(16'd12, 16'd12, 32'd1, 1);
    sendWord(hdrWord(16'd20, 16'd11), 1'b0);
    sendWord(seqWord(32'd7), 1'b0);
    sendWord(payWord(0), 1'b0);
    reset_b = 1'b0;
    #1;
    chkB("t11.val", dataOut_val, 1'b0);
    chkD("t11.data", dataOut, '0);
    chk16("t11.len", dataOut_len, 16'd0);
    chk16("t11.stream", dataOut_stream, 16'd0);
    chkB("t11.ready", dataIn_ready, 1'b1);
    @(negedge clk);
    reset_b = 1'b1;
    @(posedge clk);
    #1;
    sendMsg(16'd12, 16'd5, 32'd1, 1);
    expectHead("t11", expData(4), 16'd4, 16'd5, 1'b0, 1'b0, 32'd0);
    chkB("t11.sole", dataOut_val, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
    $finish;
  end

endmodule
`default_nettype wire
